// File: rtl/sim_pkg.sv
// Shared constants and the peak record layout for the PZC peak-capture path.
// Pure declarations: no latency or backpressure of its own.
package sim_pkg;

   localparam int PZC_BITS  = 29;
   localparam int BUNCH_POS = 3564;
   localparam int BCID_BITS = 12;
   localparam int FIFO_DEPTH = 16;
   localparam int CNT_BITS  = 16;

   // Amplitude is carried as raw two's-complement bits; consumers reinterpret as signed.
   typedef struct packed {
      logic [BCID_BITS-1:0] bcid;
      logic [PZC_BITS-1:0]  amp;
   } peak_rec_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO; head visible combinationally while not empty, push/pop take effect at the edge.
// A push into a full FIFO is accepted only when a pop happens on the same edge; otherwise the caller sees it refused.
module sync_fifo_fwft #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_push,
   input  logic [DATA_W-1:0] i_wr_dat,
   input  logic              i_pop,
   output logic [DATA_W-1:0] o_rd_dat,
   output logic              o_empty,
   output logic              o_full
);

   localparam int AW = $clog2(DEPTH);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [AW:0]       r_wr_ptr;
   logic [AW:0]       r_rd_ptr;
   logic              w_empty;
   logic              w_full;
   logic              w_pop;
   logic              w_push;

   // The extra MSB is a wrap bit that separates full from empty when addresses match.
   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
   assign w_pop   = i_pop && !w_empty;
   assign w_push  = i_push && (!w_full || w_pop);

   assign o_empty  = w_empty;
   assign o_full   = w_full;
   assign o_rd_dat = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_dat;
   end

endmodule

// File: rtl/pzc_peak_capture.sv
// Finds local maxima above threshold in the PZC stream and queues {bcid, amp}; sample at t is judged at t+2, record visible at t+3.
// Never stalls the input stream: a peak that meets a full FIFO with no pop on the same edge is dropped and counted.
module pzc_peak_capture #(
   parameter int PZC_BITS   = sim_pkg::PZC_BITS,
   parameter int BUNCH_POS  = sim_pkg::BUNCH_POS,
   parameter int BCID_BITS  = sim_pkg::BCID_BITS,
   parameter int FIFO_DEPTH = sim_pkg::FIFO_DEPTH,
   parameter bit MASK_GATE  = 1'b1,
   parameter int CNT_BITS   = sim_pkg::CNT_BITS
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic signed [PZC_BITS-1:0]    pzc_in,
   input  logic                          bt_mask_in,
   input  logic signed [PZC_BITS-1:0]    threshold,
   input  logic                          rd_en,
   output logic [BCID_BITS+PZC_BITS-1:0] rd_data,
   output logic                          empty,
   output logic                          full,
   output logic [CNT_BITS-1:0]           peak_cnt,
   output logic [CNT_BITS-1:0]           drop_cnt
);

   import sim_pkg::*;

   logic                       r_fill_sat;
   logic [1:0]                 r_fill;
   logic [BCID_BITS-1:0]       r_bcid;
   logic signed [PZC_BITS-1:0] r_s0, r_s1, r_s2;
   logic                       r_m0, r_m1;
   logic [BCID_BITS-1:0]       r_b0, r_b1;
   logic [CNT_BITS-1:0]        r_peak_cnt;
   logic [CNT_BITS-1:0]        r_drop_cnt;

   logic                       w_peak;
   logic                       w_drop;
   logic                       w_empty;
   logic                       w_full;
   peak_rec_t                  w_rec;

   // Strict on the older neighbour, non-strict on the newer one: a flat top reports once, on its first sample.
   assign w_peak = r_fill_sat
                && (r_s1 > threshold)
                && (r_s1 > r_s2)
                && (r_s1 >= r_s0)
                && (!MASK_GATE || r_m1);

   assign w_drop = w_peak && w_full && !rd_en;
   assign w_rec  = '{bcid: r_b1, amp: r_s1};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fill     <= '0;
         r_fill_sat <= 1'b0;
         r_bcid     <= '0;
         r_s0       <= '0;
         r_s1       <= '0;
         r_s2       <= '0;
         r_m0       <= 1'b0;
         r_m1       <= 1'b0;
         r_b0       <= '0;
         r_b1       <= '0;
         r_peak_cnt <= '0;
         r_drop_cnt <= '0;
      end else begin
         if (r_fill != 2'd3) r_fill <= r_fill + 2'd1;
         r_fill_sat <= (r_fill >= 2'd2);
         r_bcid     <= (r_bcid == BCID_BITS'(BUNCH_POS-1)) ? '0 : r_bcid + 1'b1;
         r_s2       <= r_s1;
         r_s1       <= r_s0;
         r_s0       <= pzc_in;
         r_m1       <= r_m0;
         r_m0       <= bt_mask_in;
         r_b1       <= r_b0;
         r_b0       <= r_bcid;
         if (w_peak && (r_peak_cnt != '1)) r_peak_cnt <= r_peak_cnt + 1'b1;
         if (w_drop && (r_drop_cnt != '1)) r_drop_cnt <= r_drop_cnt + 1'b1;
      end
   end

   sync_fifo_fwft #(
      .DATA_W (BCID_BITS+PZC_BITS),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .i_push   (w_peak),
      .i_wr_dat (w_rec),
      .i_pop    (rd_en),
      .o_rd_dat (rd_data),
      .o_empty  (w_empty),
      .o_full   (w_full)
   );

   assign empty    = w_empty;
   assign full     = w_full;
   assign peak_cnt = r_peak_cnt;
   assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_pzc_peak_capture.sv
// Drives directed and random PZC streams and compares every cycle against a sample-history model.
module tb_pzc_peak_capture;

   localparam int PB    = 29;
   localparam int BB    = 12;
   localparam int DEPTH = 16;
   localparam int BP    = 3564;
   localparam int HW    = 8192;

   logic                   clk = 1'b0;
   logic                   rst = 1'b1;
   logic signed [PB-1:0]   pzc_in = '0;
   logic                   bt_mask_in = 1'b0;
   logic signed [PB-1:0]   threshold = '0;
   logic                   rd_en = 1'b0;
   logic [BB+PB-1:0]       rd_data;
   logic                   empty;
   logic                   full;
   logic [15:0]            peak_cnt;
   logic [15:0]            drop_cnt;

   pzc_peak_capture dut (
      .clk        (clk),
      .rst        (rst),
      .pzc_in     (pzc_in),
      .bt_mask_in (bt_mask_in),
      .threshold  (threshold),
      .rd_en      (rd_en),
      .rd_data    (rd_data),
      .empty      (empty),
      .full       (full),
      .peak_cnt   (peak_cnt),
      .drop_cnt   (drop_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      int bcid;
      int amp;
   } rec_s;

   int   n_chk = 0;
   int   n_pass = 0;
   int   xh [HW];
   bit   mh [HW];
   int   t = 0;
   int   thr = 100;
   rec_s q[$];
   int   m_peak = 0;
   int   m_drop = 0;

   task automatic check_model();
      logic [BB+PB-1:0]  e_dat;
      logic [BB+PB+33:0] act;
      logic [BB+PB+33:0] exp;
      e_dat = '0;
      if (q.size() > 0) e_dat = {BB'(q[0].bcid), PB'(q[0].amp)};
      exp = {e_dat, (q.size() == 0), (q.size() == DEPTH), 16'(m_peak), 16'(m_drop)};
      act = {rd_data, empty, full, peak_cnt, drop_cnt};
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL model_cycle t=%0d actual=%h required=%h", t, act, exp);
   endtask

   task automatic check_lit(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
   endtask

   // Sample k is a peak when it beats threshold and the previous sample, and is not below the next one.
   task automatic step(input int x, input bit m, input bit rd);
      bit   pk;
      int   k;
      rec_s r;
      pzc_in     = PB'(x);
      bt_mask_in = m;
      rd_en      = rd;
      threshold  = PB'(thr);
      xh[t] = x;
      mh[t] = m;
      pk = 1'b0;
      k  = 0;
      if (t >= 3) begin
         k  = t - 2;
         pk = (xh[k] > thr) && (xh[k] > xh[k-1]) && (xh[k] >= xh[k+1]) && mh[k];
      end
      if (rd && q.size() > 0) q.delete(0);
      if (pk) begin
         if (m_peak < 65535) m_peak++;
         if (q.size() < DEPTH) begin
            r.bcid = k % BP;
            r.amp  = xh[k];
            q.push_back(r);
         end else if (m_drop < 65535) begin
            m_drop++;
         end
      end
      t++;
      @(negedge clk);
      check_model();
   endtask

   task automatic idle_to(input int tt, input bit rd);
      while (t < tt) step(0, 1'b1, rd);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      pzc_in = '0; bt_mask_in = 1'b0; rd_en = 1'b0; threshold = PB'(thr);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      t = 0; q.delete(); m_peak = 0; m_drop = 0;
      check_model();
   endtask

   initial begin
      thr = 100;
      do_reset();

      // Quiet input: nothing may ever be captured.
      idle_to(10, 1'b0);
      check_lit("t1_empty", empty, 1);
      check_lit("t1_peak_cnt", peak_cnt, 0);
      check_lit("t1_drop_cnt", drop_cnt, 0);

      // Isolated pulse, 300 at BCID 17.
      idle_to(16, 1'b0);
      step(50, 1'b1, 1'b0);
      step(300, 1'b1, 1'b0);
      step(120, 1'b1, 1'b0);
      check_lit("t2_empty_still_hi", empty, 1);
      step(0, 1'b1, 1'b0);
      check_lit("t2_empty_lo", empty, 0);
      check_lit("t2_rec", rd_data, {12'd17, 29'd300});

      // Flat top (mask=1) then the same pulse masked off.
      idle_to(30, 1'b0);
      step(200, 1'b1, 1'b0);
      step(200, 1'b1, 1'b0);
      idle_to(40, 1'b0);
      step(200, 1'b0, 1'b0);
      step(200, 1'b0, 1'b0);
      step(0, 1'b0, 1'b0);
      idle_to(50, 1'b0);
      check_lit("t3_peak_cnt", peak_cnt, 2);
      check_lit("t3_model_peaks", m_peak, 2);
      step(0, 1'b1, 1'b1);
      check_lit("t3_flat_rec", rd_data, {12'd30, 29'd200});
      step(0, 1'b1, 1'b1);
      check_lit("t3_empty_after_drain", empty, 1);

      // BCID wrap: peak at 3563, next orbit peak at BCID 0.
      idle_to(3563, 1'b0);
      step(500, 1'b1, 1'b0);
      step(0, 1'b1, 1'b0);
      step(0, 1'b1, 1'b0);
      check_lit("t4_rec_3563", rd_data, {12'd3563, 29'd500});
      idle_to(3570, 1'b0);
      step(0, 1'b1, 1'b1);
      idle_to(7128, 1'b0);
      step(700, 1'b1, 1'b0);
      step(0, 1'b1, 1'b0);
      step(0, 1'b1, 1'b0);
      check_lit("t4_rec_0", rd_data, {12'd0, 29'd700});
      step(0, 1'b1, 1'b1);

      // 20 peaks into a 16-deep FIFO with no reads.
      for (int i = 0; i < 60; i++) step((i % 3 == 1) ? 200 + i : 0, 1'b1, 1'b0);
      repeat (3) step(0, 1'b1, 1'b0);
      check_lit("t5_full", full, 1);
      check_lit("t5_drop_cnt", drop_cnt, 4);
      check_lit("t5_peak_cnt", peak_cnt, 24);
      check_lit("t5_first_amp", rd_data[PB-1:0], 201);
      for (int i = 0; i < 16; i++) begin
         if (i == 15) check_lit("t5_last_amp", rd_data[PB-1:0], 246);
         step(0, 1'b1, 1'b1);
      end
      check_lit("t5_empty", empty, 1);

      // Refill, then a peak lands on the same edge as a pop.
      for (int i = 0; i < 48; i++) step((i % 3 == 1) ? 300 + i : 0, 1'b1, 1'b0);
      step(0, 1'b1, 1'b0);
      step(900, 1'b1, 1'b0);
      step(0, 1'b1, 1'b0);
      check_lit("t6_full_before", full, 1);
      step(0, 1'b1, 1'b1);
      check_lit("t6_full_after", full, 1);
      check_lit("t6_drop_cnt", drop_cnt, 4);
      check_lit("t6_peak_cnt", peak_cnt, 41);
      repeat (3) step(0, 1'b1, 1'b0);

      // Asynchronous reset mid-stream.
      #2;
      rst = 1'b1;
      #1;
      check_lit("t6_rst_empty", empty, 1);
      check_lit("t6_rst_full", full, 0);
      check_lit("t6_rst_peak_cnt", peak_cnt, 0);
      check_lit("t6_rst_drop_cnt", drop_cnt, 0);
      check_lit("t6_rst_rd_data", rd_data, 0);
      do_reset();

      // Random traffic, including negative samples and a negative threshold.
      for (int i = 0; i < 1500; i++) begin
         if (i == 750) thr = -60;
         step(int'($urandom_range(0, 600)) - 200,
              ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 9) < 3));
      end
      repeat (20) step(0, 1'b1, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
